// File: rtl/voice_sequencer.sv
// voice_sequencer: shares one phase2sample interpolator across VOICES voices.
// Each sample_tick steps every voice's phase accumulator, issues one lookup per
// voice, collects the pipelined results and emits their unsigned sum.
module voice_sequencer #(
  parameter int VOICES      = 8,
  parameter int ACC_W       = 16,
  parameter int P2S_LATENCY = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic                          cfg_we,
  input  logic [$clog2(VOICES)-1:0]     cfg_voice,
  input  logic [1:0]                    cfg_sel,
  input  logic [ACC_W-1:0]              cfg_data,
  output logic                          p2s_ce,
  output logic [6:0]                    p2s_nco_phase,
  output logic [7:0]                    p2s_wfm_num_l,
  output logic [7:0]                    p2s_wfm_num_r,
  output logic [7:0]                    p2s_factor,
  input  logic [7:0]                    p2s_sample,
  output logic [8+$clog2(VOICES)-1:0]   mix_out,
  output logic                          mix_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IDX_W = $clog2(VOICES);
  localparam int MIX_W = 8 + IDX_W;
  localparam int CNT_W = (P2S_LATENCY > 1) ? $clog2(P2S_LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(P2S_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [P2S_LATENCY-1:0] vld_q, vld_d;
  logic [MIX_W-1:0]       sum_q, sum_d;

  logic [ACC_W-1:0] inc_q [VOICES];
  logic [ACC_W-1:0] acc_q [VOICES];
  logic [7:0]       wl_q  [VOICES];
  logic [7:0]       wr_q  [VOICES];
  logic [7:0]       fac_q [VOICES];

  logic             ce_q, ce_d;
  logic [6:0]       ph_q, ph_d;
  logic [7:0]       owl_q, owl_d;
  logic [7:0]       owr_q, owr_d;
  logic [7:0]       ofac_q, ofac_d;
  logic [MIX_W-1:0] mix_q, mix_d;
  logic             mv_q, mv_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;

  // Sequencer state, capture pipeline and running mix sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      sum_q   <= sum_d;
    end
  end

  // Next state: issue every voice, drain the interpolator pipeline, then report.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          state_d = S_ISSUE;
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Track real issues through the pipeline and accumulate their samples at the tap.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = (state_q == S_ISSUE);
    for (int i = 1; i < P2S_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    if (state_q == S_IDLE) begin
      sum_d = '0;
    end else if (vld_q[P2S_LATENCY-1]) begin
      sum_d = sum_q + MIX_W'(p2s_sample);
    end else begin
      sum_d = sum_q;
    end
  end

  // Output values for the coming cycle, derived from the next state so they are registered.
  always_comb begin
    ce_d   = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    busy_d = (state_d != S_IDLE);
    mv_d   = (state_d == S_DONE);
    ovr_d  = ovr_q | (sample_tick && (state_q != S_IDLE));
    if (state_d == S_DONE) begin
      mix_d = sum_d;
    end else begin
      mix_d = mix_q;
    end
    if (state_d == S_ISSUE) begin
      ph_d   = acc_q[idx_d][ACC_W-1 -: 7];
      owl_d  = wl_q[idx_d];
      owr_d  = wr_q[idx_d];
      ofac_d = fac_q[idx_d];
    end else begin
      ph_d   = ph_q;
      owl_d  = owl_q;
      owr_d  = owr_q;
      ofac_d = ofac_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q   <= 1'b0;
      ph_q   <= 7'd0;
      owl_q  <= 8'd0;
      owr_q  <= 8'd0;
      ofac_q <= 8'd0;
      mix_q  <= '0;
      mv_q   <= 1'b0;
      busy_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ce_q   <= ce_d;
      ph_q   <= ph_d;
      owl_q  <= owl_d;
      owr_q  <= owr_d;
      ofac_q <= ofac_d;
      mix_q  <= mix_d;
      mv_q   <= mv_d;
      busy_q <= busy_d;
      ovr_q  <= ovr_d;
    end
  end

  // Host-visible per-voice configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        inc_q[i] <= '0;
        wl_q[i]  <= 8'd0;
        wr_q[i]  <= 8'd0;
        fac_q[i] <= 8'd0;
      end
    end else if (cfg_we) begin
      case (cfg_sel)
        2'd0:    inc_q[cfg_voice] <= cfg_data;
        2'd1:    wl_q[cfg_voice]  <= cfg_data[7:0];
        2'd2:    wr_q[cfg_voice]  <= cfg_data[7:0];
        2'd3:    fac_q[cfg_voice] <= cfg_data[7:0];
        default: ;
      endcase
    end
  end

  // Phase accumulators advance when their voice is loaded, so the lookup sees the old phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        acc_q[i] <= '0;
      end
    end else if (state_d == S_ISSUE) begin
      acc_q[idx_d] <= acc_q[idx_d] + inc_q[idx_d];
    end
  end

  assign p2s_ce        = ce_q;
  assign p2s_nco_phase = ph_q;
  assign p2s_wfm_num_l = owl_q;
  assign p2s_wfm_num_r = owr_q;
  assign p2s_factor    = ofac_q;
  assign mix_out       = mix_q;
  assign mix_valid     = mv_q;
  assign busy          = busy_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_voice_sequencer.sv
// Self-checking bench for voice_sequencer with a behavioural phase2sample model
// and a frame-level reference model of the voices.
module tb_voice_sequencer;
  localparam int V  = 8;
  localparam int P  = 3;
  localparam int AW = 16;
  localparam int IW = $clog2(V);
  localparam int MW = 8 + IW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, sample_tick = 1'b0, cfg_we = 1'b0;
  logic [IW-1:0] cfg_voice = '0;
  logic [1:0] cfg_sel = 2'd0;
  logic [AW-1:0] cfg_data = '0;
  logic p2s_ce, mix_valid, busy, overrun;
  logic [6:0] p2s_nco_phase;
  logic [7:0] p2s_wfm_num_l, p2s_wfm_num_r, p2s_factor, p2s_sample;
  logic [MW-1:0] mix_out;

  int n_checks = 0;
  int n_fail = 0;
  int mode = 0;

  voice_sequencer #(.VOICES(V), .ACC_W(AW), .P2S_LATENCY(P)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .cfg_we(cfg_we),
    .cfg_voice(cfg_voice), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .p2s_ce(p2s_ce), .p2s_nco_phase(p2s_nco_phase), .p2s_wfm_num_l(p2s_wfm_num_l),
    .p2s_wfm_num_r(p2s_wfm_num_r), .p2s_factor(p2s_factor), .p2s_sample(p2s_sample),
    .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
  );

  // Interpolator stand-in: 0 = constant 0x40, 1 = echo left table, 2 = mixing hash.
  function automatic logic [7:0] p2s_f(input int m, input logic [6:0] ph, input logic [7:0] l,
                                       input logic [7:0] r, input logic [7:0] fc);
    logic [7:0] h;
    case (m)
      0:       h = 8'h40;
      1:       h = l;
      default: h = ({1'b0, ph} * 8'd5) ^ (l + r) ^ {fc[3:0], fc[7:4]};
    endcase
    return h;
  endfunction

  logic [7:0] pipe [P];
  always @(posedge clk) begin
    if (p2s_ce) begin
      pipe[0] <= p2s_f(mode, p2s_nco_phase, p2s_wfm_num_l, p2s_wfm_num_r, p2s_factor);
      for (int i = 1; i < P; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign p2s_sample = pipe[P-1];

  // Reference model state
  logic [AW-1:0] r_inc [V];
  logic [AW-1:0] r_acc [V];
  logic [7:0] r_wl [V], r_wr [V], r_fac [V];
  logic [6:0] e_ph [V];
  logic [MW-1:0] e_mix;

  function automatic void ref_reset();
    for (int v = 0; v < V; v++) begin
      r_inc[v] = '0; r_acc[v] = '0; r_wl[v] = 8'd0; r_wr[v] = 8'd0; r_fac[v] = 8'd0;
    end
  endfunction

  function automatic void ref_write(input int v, input int sel, input logic [AW-1:0] d);
    case (sel)
      0: r_inc[v] = d;
      1: r_wl[v] = d[7:0];
      2: r_wr[v] = d[7:0];
      default: r_fac[v] = d[7:0];
    endcase
  endfunction

  function automatic void ref_frame();
    e_mix = '0;
    for (int v = 0; v < V; v++) begin
      e_ph[v] = 7'(r_acc[v] >> (AW - 7));
      e_mix = e_mix + MW'(p2s_f(mode, e_ph[v], r_wl[v], r_wr[v], r_fac[v]));
      r_acc[v] = r_acc[v] + r_inc[v];
    end
  endfunction

  // Observations from one frame
  int lat, ce_cnt, busy_cnt, vcnt;
  logic [MW-1:0] mix_seen;
  logic [6:0] o_ph [V];
  logic [7:0] o_wl [V], o_wr [V], o_fac [V], o_smp [V];

  task automatic run_frame(input int tick2_at, input int wr_at, input int wr_v, input int wr_sel,
                           input int wr_data, input int rst_at);
    lat = -1; ce_cnt = 0; busy_cnt = 0; vcnt = 0; mix_seen = '0;
    @(negedge clk);
    sample_tick = 1'b1;
    for (int k = 1; k <= V + P + 4; k++) begin
      @(negedge clk);
      sample_tick = 1'b0; cfg_we = 1'b0; rst = 1'b0;
      if (p2s_ce) ce_cnt++;
      if (busy) busy_cnt++;
      if (k <= V) begin
        o_ph[k-1] = p2s_nco_phase; o_wl[k-1] = p2s_wfm_num_l;
        o_wr[k-1] = p2s_wfm_num_r; o_fac[k-1] = p2s_factor;
      end
      if (k > P && k <= P + V) o_smp[k-P-1] = p2s_sample;
      if (mix_valid) begin
        vcnt++;
        if (lat < 0) begin lat = k; mix_seen = mix_out; end
      end
      if (k == tick2_at) sample_tick = 1'b1;
      if (k == wr_at) begin
        cfg_we = 1'b1; cfg_voice = IW'(wr_v); cfg_sel = 2'(wr_sel); cfg_data = AW'(wr_data);
      end
      if (k == rst_at) rst = 1'b1;
    end
  endtask

  task automatic cfg_write(input int v, input int sel, input logic [AW-1:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_voice = IW'(v); cfg_sel = 2'(sel); cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    ref_write(v, sel, d);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    ref_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({p2s_ce, mix_valid, busy, overrun} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {p2s_ce, mix_valid, busy, overrun});
    end
    n_checks++;
    if ({p2s_nco_phase, p2s_wfm_num_l, p2s_wfm_num_r, p2s_factor} !== 31'd0) begin
      n_fail++; $display("FAIL reset_p2s: got %h expected 0", {p2s_nco_phase, p2s_wfm_num_l, p2s_wfm_num_r, p2s_factor});
    end
    n_checks++;
    if (mix_out !== '0) begin n_fail++; $display("FAIL reset_mix: got %h expected 0", mix_out); end
    rst = 1'b0; ref_reset();
    run_frame(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (lat !== V + P + 1) begin n_fail++; $display("FAIL zero_latency: got %0d expected %0d", lat, V + P + 1); end
    n_checks++;
    if (mix_seen !== '0) begin n_fail++; $display("FAIL zero_mix: got %h expected 0", mix_seen); end
  endtask

  task automatic test_constant();
    do_reset(); mode = 0;
    run_frame(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (mix_seen !== 11'h200) begin n_fail++; $display("FAIL const_mix: got %h expected 200", mix_seen); end
    n_checks++;
    if (ce_cnt !== V + P) begin n_fail++; $display("FAIL const_ce_cycles: got %0d expected %0d", ce_cnt, V + P); end
    n_checks++;
    if (busy_cnt !== V + P + 1) begin n_fail++; $display("FAIL const_busy_cycles: got %0d expected %0d", busy_cnt, V + P + 1); end
    n_checks++;
    if (vcnt !== 1) begin n_fail++; $display("FAIL const_valid_count: got %0d expected 1", vcnt); end
  endtask

  task automatic test_phase_step();
    int others;
    do_reset(); mode = 1;
    cfg_write(0, 0, 16'h0200);
    for (int f = 0; f < 130; f++) begin
      ref_frame();
      run_frame(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (o_ph[0] !== 7'(f % 128) || o_ph[0] !== e_ph[0]) begin
        n_fail++; $display("FAIL phase_v0 frame %0d: got %0d expected %0d", f, o_ph[0], f % 128);
      end
      others = 0;
      for (int v = 1; v < V; v++) if (o_ph[v] !== 7'd0) others++;
      n_checks++;
      if (others !== 0) begin n_fail++; $display("FAIL phase_others frame %0d: got %0d nonzero expected 0", f, others); end
    end
  endtask

  task automatic test_routing();
    logic [MW-1:0] exp_sum;
    do_reset(); mode = 1;
    exp_sum = '0;
    for (int v = 0; v < V; v++) begin
      cfg_write(v, 1, AW'(16 + v));
      exp_sum = exp_sum + MW'(16 + v);
    end
    run_frame(0, 0, 0, 0, 0, 0);
    for (int v = 0; v < V; v++) begin
      n_checks++;
      if (o_smp[v] !== 8'(16 + v)) begin n_fail++; $display("FAIL route_order v%0d: got %h expected %h", v, o_smp[v], 16 + v); end
    end
    n_checks++;
    if (mix_seen !== exp_sum) begin n_fail++; $display("FAIL route_mix: got %h expected %h", mix_seen, exp_sum); end
    for (int v = 0; v < V; v++) cfg_write(v, 1, 16'h00FF);
    run_frame(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (mix_seen !== 11'h7F8) begin n_fail++; $display("FAIL route_fullscale: got %h expected 7f8", mix_seen); end
  endtask

  task automatic test_overrun();
    do_reset(); mode = 0;
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_initial: got %b expected 0", overrun); end
    run_frame(5, 0, 0, 0, 0, 0);
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    n_checks++;
    if (vcnt !== 1 || mix_seen !== 11'h200) begin
      n_fail++; $display("FAIL ovr_single_frame: got %0d valids mix %h expected 1 valid mix 200", vcnt, mix_seen);
    end
    run_frame(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (vcnt !== 1 || lat !== V + P + 1 || mix_seen !== 11'h200) begin
      n_fail++; $display("FAIL ovr_next_frame: got valids %0d lat %0d mix %h expected 1 %0d 200", vcnt, lat, mix_seen, V + P + 1);
    end
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_collision();
    do_reset(); mode = 1;
    cfg_write(3, 3, 16'h006A);
    run_frame(0, 4, 3, 3, 'hCF, 0);
    n_checks++;
    if (o_fac[3] !== 8'h6A) begin n_fail++; $display("FAIL coll_same_frame: got %h expected 6a", o_fac[3]); end
    run_frame(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (o_fac[3] !== 8'hCF) begin n_fail++; $display("FAIL coll_next_frame: got %h expected cf", o_fac[3]); end
    run_frame(0, 4, 6, 3, 'h55, 0);
    n_checks++;
    if (o_fac[6] !== 8'h55) begin n_fail++; $display("FAIL coll_other_voice: got %h expected 55", o_fac[6]); end
  endtask

  task automatic test_reset_midframe();
    int bad;
    do_reset(); mode = 1;
    for (int v = 0; v < V; v++) begin
      cfg_write(v, 0, AW'(16'h0200 | $urandom_range(0, 16'h7FFF)));
      cfg_write(v, 1, AW'($urandom_range(1, 255)));
    end
    ref_frame();
    run_frame(0, 0, 0, 0, 0, 0);
    run_frame(0, 0, 0, 0, 0, 4);
    n_checks++;
    if (vcnt !== 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d expected 0", vcnt); end
    n_checks++;
    if ({busy, p2s_ce} !== 2'b00) begin n_fail++; $display("FAIL rstmid_idle: got %b expected 00", {busy, p2s_ce}); end
    ref_reset(); ref_frame();
    run_frame(0, 0, 0, 0, 0, 0);
    bad = 0;
    for (int v = 0; v < V; v++) if (o_ph[v] !== e_ph[v]) bad++;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL rstmid_acc_cleared: got %0d voices off expected 0", bad); end
    n_checks++;
    if (mix_seen !== e_mix) begin n_fail++; $display("FAIL rstmid_mix: got %h expected %h", mix_seen, e_mix); end
  endtask

  task automatic test_random();
    do_reset(); mode = 2;
    for (int v = 0; v < V; v++)
      for (int s = 0; s < 4; s++) cfg_write(v, s, AW'($urandom));
    for (int f = 0; f < 24; f++) begin
      ref_frame();
      run_frame(0, 0, 0, 0, 0, 0);
      for (int v = 0; v < V; v++) begin
        n_checks++;
        if ({o_ph[v], o_wl[v], o_wr[v], o_fac[v]} !== {e_ph[v], r_wl[v], r_wr[v], r_fac[v]}) begin
          n_fail++; $display("FAIL rand_issue f%0d v%0d: got %h expected %h", f, v,
                             {o_ph[v], o_wl[v], o_wr[v], o_fac[v]}, {e_ph[v], r_wl[v], r_wr[v], r_fac[v]});
        end
      end
      n_checks++;
      if (lat !== V + P + 1 || mix_seen !== e_mix) begin
        n_fail++; $display("FAIL rand_mix f%0d: got lat %0d mix %h expected %0d %h", f, lat, mix_seen, V + P + 1, e_mix);
      end
      if ($urandom_range(0, 1) == 1) cfg_write($urandom_range(0, V - 1), $urandom_range(0, 3), AW'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_phase_step();
    test_routing();
    test_overrun();
    test_collision();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
